// File: rtl/rv32_fetch_stage.sv
// Instruction fetch stage: issues sequential word fetches under a credit limit,
// queues returned words with their PCs, and hands {pc, instr} to decode.
module rv32_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 2;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t             LAST_PTR     = ptr_t'(DEPTH - 1);
  localparam logic [SUM_W-1:0] CREDIT_LIMIT = SUM_W'(DEPTH);

  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  logic [31:0] pc_q, pc_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        discard_q, discard_d;
  cnt_t        count_q, count_d;
  ptr_t        pcq_head_q, pcq_head_d, pcq_tail_q, pcq_tail_d;
  ptr_t        fifo_head_q, fifo_head_d, fifo_tail_q, fifo_tail_d;

  logic [31:0] pcq_mem        [DEPTH];
  logic [31:0] fifo_pc_mem    [DEPTH];
  logic [31:0] fifo_instr_mem [DEPTH];

  logic             req_fire, rsp_drop, rsp_keep, fifo_push, fifo_pop;
  logic [SUM_W-1:0] in_use;

  // outstanding counts live requests only; on redirect they move into discard,
  // so every in-flight response is counted exactly once across the two.
  always_comb begin
    in_use         = SUM_W'(outstanding_q) + SUM_W'(count_q) + SUM_W'(discard_q);
    imem_req_valid = !rst && !redirect && (in_use < CREDIT_LIMIT);
    imem_req_addr  = pc_q & 32'hFFFF_FFFC;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (discard_q != '0);
    rsp_keep       = imem_rsp_valid && (discard_q == '0);
    fetch_valid    = (count_q != '0) && !redirect;
    fetch_pc       = (count_q != '0) ? fifo_pc_mem[fifo_head_q]    : '0;
    fetch_instr    = (count_q != '0) ? fifo_instr_mem[fifo_head_q] : '0;
    fifo_push      = rsp_keep && !redirect;
    fifo_pop       = fetch_valid && fetch_ready;
  end

  // NOTE: every _d starts from its _q so no path through this block infers a latch.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    pcq_head_d    = pcq_head_q;
    pcq_tail_d    = pcq_tail_q;
    fifo_head_d   = fifo_head_q;
    fifo_tail_d   = fifo_tail_q;

    if (req_fire) begin
      pc_d       = pc_q + 32'd4;
      pcq_tail_d = ptr_next(pcq_tail_q);
    end
    if (imem_rsp_valid) pcq_head_d = ptr_next(pcq_head_q);

    if (redirect) begin
      pc_d          = redirect_pc & 32'hFFFF_FFFC;
      outstanding_d = '0;
      discard_d     = discard_q + outstanding_q - cnt_t'(imem_rsp_valid);
      count_d       = '0;
      fifo_head_d   = '0;
      fifo_tail_d   = '0;
    end else begin
      outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp_keep);
      discard_d     = discard_q - cnt_t'(rsp_drop);
      count_d       = count_q + cnt_t'(fifo_push) - cnt_t'(fifo_pop);
      if (fifo_push) fifo_tail_d = ptr_next(fifo_tail_q);
      if (fifo_pop)  fifo_head_d = ptr_next(fifo_head_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      pcq_head_q    <= '0;
      pcq_tail_q    <= '0;
      fifo_head_q   <= '0;
      fifo_tail_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      pcq_head_q    <= pcq_head_d;
      pcq_tail_q    <= pcq_tail_d;
      fifo_head_q   <= fifo_head_d;
      fifo_tail_q   <= fifo_tail_d;
    end
  end

  // NOTE: storage arrays are not reset; occupancy lives in the counters and pointers.
  always_ff @(posedge clk) begin
    if (req_fire) pcq_mem[pcq_tail_q] <= imem_req_addr;
    if (fifo_push) begin
      fifo_pc_mem[fifo_tail_q]    <= pcq_mem[pcq_head_q];
      fifo_instr_mem[fifo_tail_q] <= imem_rsp_data;
    end
  end

  // A response with nothing in flight means memory and fetch disagree on credit.
  assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((outstanding_q != '0) || (discard_q != '0)));

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Directed bench for rv32_fetch_stage: 1-cycle in-order memory model with a
// hold switch, and a decode scoreboard expecting consecutive PCs and words.
module tb_rv32_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_pc, fetch_instr;

  rv32_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t        vecs [5];
  int          total = 0;
  int          bad   = 0;
  int          req_fires;
  bit          mem_hold;
  logic [31:0] exp_pc;
  logic [31:0] mq [$];
  logic [31:0] hs_pcs [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + 32'h0F0F_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  // One clock: sample handshakes, advance, then update the memory model.
  task automatic tick();
    logic        fire, took, hs, rst_s;
    logic [31:0] a, hpc, hinstr;
    #1;
    fire   = imem_req_valid && imem_req_ready;
    a      = imem_req_addr;
    took   = imem_rsp_valid;
    hs     = fetch_valid && fetch_ready;
    hpc    = fetch_pc;
    hinstr = fetch_instr;
    rst_s  = rst;
    if (hs) begin
      check("dec_pc", hpc, exp_pc);
      check("dec_instr", hinstr, mem_word(exp_pc));
      hs_pcs.push_back(hpc);
      exp_pc = exp_pc + 32'd4;
    end
    if (fire) req_fires++;
    @(posedge clk);
    #1;
    if (rst_s) mq.delete();
    else begin
      if (took) void'(mq.pop_front());
      if (fire) mq.push_back(a);
    end
    if (!rst_s && mq.size() > 0 && !mem_hold) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset(input logic fr);
    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = fr;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    tick();
    #1;
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_fetch_valid", fetch_valid, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'd0);
    check("rst_fetch_instr", fetch_instr, 32'd0);
    rst       = 1'b0;
    exp_pc    = 32'h0;
    req_fires = 0;
    hs_pcs.delete();
  endtask

  task automatic wait_req(input int bound, output bit ok);
    #1;
    for (int i = 0; i < bound && !imem_req_valid; i++) begin
      tick();
      #1;
    end
    ok = imem_req_valid;
  endtask

  task automatic wait_hs(input int mark, input int bound, output bit ok);
    for (int i = 0; i < bound && hs_pcs.size() <= mark; i++) tick();
    ok = hs_pcs.size() > mark;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mark;
    bit ok;
    vecs[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h8000_0003, 32'h8000_0000, 32'h8000_0004};
    vecs[4] = '{32'h0000_0FF8, 32'h0000_0FF8, 32'h0000_0FFC};
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    // Sequential fetch with exact first-cycle timing.
    do_reset(1'b1);
    #1;
    check("c0_req_valid", imem_req_valid, 32'd1);
    check("c0_req_addr", imem_req_addr, 32'h0);
    check("c0_fetch_valid", fetch_valid, 32'd0);
    tick(); #1;
    check("c1_req_addr", imem_req_addr, 32'h4);
    check("c1_no_bypass", fetch_valid, 32'd0);
    tick(); #1;
    check("c2_fetch_valid", fetch_valid, 32'd1);
    check("c2_fetch_pc", fetch_pc, 32'h0);
    check("c2_fetch_instr", fetch_instr, mem_word(32'h0));
    check("c2_credit_stall", imem_req_valid, 32'd0);
    tick(); #1;
    check("c3_fetch_pc", fetch_pc, 32'h4);
    check("c3_req_addr", imem_req_addr, 32'h8);
    repeat (11) tick();
    check("steady_progress", 32'(hs_pcs.size() >= 8), 32'd1);

    // Decode stalled: credit caps issue at DEPTH.
    do_reset(1'b0);
    repeat (10) tick();
    #1;
    check("stall_req_count", req_fires, 32'd2);
    check("stall_req_valid", imem_req_valid, 32'd0);
    check("stall_fetch_valid", fetch_valid, 32'd1);
    check("stall_fetch_pc", fetch_pc, 32'h0);
    fetch_ready = 1'b1;
    repeat (4) tick();
    check("release_delivered", 32'(hs_pcs.size() >= 2), 32'd1);

    // Reset from a populated state, then request address hold.
    fetch_ready = 1'b0;
    repeat (5) tick();
    do_reset(1'b1);
    tick(); tick();
    imem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_req_valid", imem_req_valid, 32'd1);
      check("hold_req_addr", imem_req_addr, 32'h8);
      tick();
    end
    imem_req_ready = 1'b1;
    #1;
    check("hold_accept_addr", imem_req_addr, 32'h8);
    tick(); #1;
    check("hold_next_addr", imem_req_addr, 32'hC);

    // Redirect with two requests (0x8, 0xC) in flight.
    do_reset(1'b1);
    tick(); tick(); tick();
    mem_hold = 1'b1;
    tick(); tick(); #1;
    check("inflight2_req_valid", imem_req_valid, 32'd0);
    check("inflight2_fetch_valid", fetch_valid, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    mem_hold    = 1'b0;
    exp_pc      = 32'h100;
    mark        = hs_pcs.size();
    #1;
    check("redir_no_req", imem_req_valid, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("redir_discard_stall", imem_req_valid, 32'd0);
    check("redir_fifo_empty", fetch_valid, 32'd0);
    wait_req(10, ok);
    check("redir_req_found", 32'(ok), 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h100);
    wait_hs(mark, 20, ok);
    check("redir_hs_found", 32'(ok), 32'd1);
    if (ok) check("redir_first_pc", hs_pcs[mark], 32'h100);

    // Redirect coinciding with a response and a decode pop.
    do_reset(1'b1);
    tick(); tick(); #1;
    check("coinc_pre_valid", fetch_valid, 32'd1);
    check("coinc_pre_rsp", imem_rsp_valid, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    exp_pc      = 32'h200;
    mark        = hs_pcs.size();
    #1;
    check("coinc_fetch_valid", fetch_valid, 32'd0);
    check("coinc_req_valid", imem_req_valid, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("coinc_after_fetch_valid", fetch_valid, 32'd0);
    check("coinc_after_req_valid", imem_req_valid, 32'd1);
    check("coinc_after_req_addr", imem_req_addr, 32'h200);
    wait_hs(mark, 20, ok);
    check("coinc_hs_found", 32'(ok), 32'd1);
    if (ok) check("coinc_first_pc", hs_pcs[mark], 32'h200);

    // Back-to-back redirects: the last target wins.
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    exp_pc      = 32'h400;
    tick();
    redirect_pc = 32'h400;
    mark        = hs_pcs.size();
    #1;
    check("b2b_no_req", imem_req_valid, 32'd0);
    tick();
    redirect = 1'b0;
    wait_req(10, ok);
    check("b2b_req_found", 32'(ok), 32'd1);
    check("b2b_req_addr", imem_req_addr, 32'h400);
    wait_hs(mark, 20, ok);
    check("b2b_hs_found", 32'(ok), 32'd1);
    if (ok) check("b2b_first_pc", hs_pcs[mark], 32'h400);

    // Alignment and wrap vectors.
    for (int i = 0; i < 5; i++) begin
      redirect    = 1'b1;
      redirect_pc = vecs[i].target;
      exp_pc      = vecs[i].exp_addr;
      mark        = hs_pcs.size();
      tick();
      redirect = 1'b0;
      wait_req(20, ok);
      check("vec_req_found", 32'(ok), 32'd1);
      check("vec_req_addr", imem_req_addr, vecs[i].exp_addr);
      tick();
      wait_req(20, ok);
      check("vec_next_found", 32'(ok), 32'd1);
      check("vec_next_addr", imem_req_addr, vecs[i].exp_next);
      wait_hs(mark, 20, ok);
      check("vec_hs_found", 32'(ok), 32'd1);
      if (ok) check("vec_first_pc", hs_pcs[mark], vecs[i].exp_addr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
